// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer
// Runs one single-precision add/sub/mul at a time through the shared multi-cycle FP core.
// IEEE special cases (NaN, inf, zero, reserved op) are resolved locally without using the core.
// Core requests have a bounded wait: if the core never answers, a quiet NaN is returned with the timeout flag set.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | in_ready=1, waiting for a request
//   CLASSIFY | operands latched; decide special case vs core issue
//   ISSUE    | core_start pulse, wait counter cleared
//   WAIT     | waiting for core_done or timeout
//   RESP     | out_valid held until out_ready

module fp_op_sequencer #(
    parameter int unsigned TIMEOUT = 64,
    parameter logic [31:0] QNAN    = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_op,
    output logic        core_start,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_op,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_invalid,
    output logic        out_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [7:0]  r_cnt;

    logic        w_a_sign, w_b_sign;
    logic        w_a_zero, w_b_zero;
    logic        w_a_inf,  w_b_inf;
    logic        w_a_nan,  w_b_nan;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic        w_spec_inv;

    assign in_ready = (r_state == S_IDLE);

    // core_b already carries the flipped sign for sub, so classification works directly on the latched operands
    assign w_a_sign = core_a[31];
    assign w_b_sign = core_b[31];
    assign w_a_zero = (core_a[30:23] == 8'h00) && (core_a[22:0] == 23'd0);
    assign w_b_zero = (core_b[30:23] == 8'h00) && (core_b[22:0] == 23'd0);
    assign w_a_inf  = (core_a[30:23] == 8'hFF) && (core_a[22:0] == 23'd0);
    assign w_b_inf  = (core_b[30:23] == 8'hFF) && (core_b[22:0] == 23'd0);
    assign w_a_nan  = (core_a[30:23] == 8'hFF) && (core_a[22:0] != 23'd0);
    assign w_b_nan  = (core_b[30:23] == 8'hFF) && (core_b[22:0] != 23'd0);

    // Special-case resolution, rules checked in priority order
    always_comb begin
        w_special  = 1'b0;
        w_spec_res = '0;
        w_spec_inv = 1'b0;
        if (r_op == 2'd3) begin
            w_special  = 1'b1;
            w_spec_res = QNAN;
            w_spec_inv = 1'b1;
        end else if (r_op == 2'd2) begin
            if (w_a_nan || w_b_nan) begin
                w_special  = 1'b1;
                w_spec_res = QNAN;
                w_spec_inv = 1'b1;
            end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
                w_special  = 1'b1;
                w_spec_res = QNAN;
                w_spec_inv = 1'b1;
            end else if (w_a_inf || w_b_inf) begin
                w_special  = 1'b1;
                w_spec_res = {w_a_sign ^ w_b_sign, 8'hFF, 23'd0};
            end else if (w_a_zero || w_b_zero) begin
                w_special  = 1'b1;
                w_spec_res = {w_a_sign ^ w_b_sign, 31'd0};
            end
        end else begin
            if (w_a_nan || w_b_nan) begin
                w_special  = 1'b1;
                w_spec_res = QNAN;
                w_spec_inv = 1'b1;
            end else if (w_a_inf && w_b_inf && (w_a_sign != w_b_sign)) begin
                w_special  = 1'b1;
                w_spec_res = QNAN;
                w_spec_inv = 1'b1;
            end else if (w_a_inf) begin
                w_special  = 1'b1;
                w_spec_res = core_a;
            end else if (w_b_inf) begin
                w_special  = 1'b1;
                w_spec_res = core_b;
            end else if (w_a_zero && w_b_zero) begin
                w_special  = 1'b1;
                w_spec_res = {w_a_sign & w_b_sign, 31'd0};
            end else if (w_a_zero) begin
                w_special  = 1'b1;
                w_spec_res = core_b;
            end else if (w_b_zero) begin
                w_special  = 1'b1;
                w_spec_res = core_a;
            end
        end
    end

    // Sequencer FSM with registered core and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 2'd0;
            r_cnt       <= 8'd0;
            core_start  <= 1'b0;
            core_a      <= 32'd0;
            core_b      <= 32'd0;
            core_op     <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= 32'd0;
            out_invalid <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        core_a  <= in_a;
                        core_b  <= (in_op == 2'd1) ? {~in_b[31], in_b[30:0]} : in_b;
                        core_op <= (in_op == 2'd2);
                        r_op    <= in_op;
                        r_state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (w_special) begin
                        out_result  <= w_spec_res;
                        out_invalid <= w_spec_inv;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        core_start <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        out_result  <= core_result;
                        out_invalid <= 1'b0;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        out_result  <= QNAN;
                        out_invalid <= 1'b0;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer (TIMEOUT=8): special cases, core path, timeout, hold, reset abort.

module tb_fp_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        core_start;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_op;
    logic        core_done;
    logic [31:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
    logic        out_timeout;

    fp_op_sequencer #(.TIMEOUT(8), .QNAN(32'h7FC00000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_op     (core_op),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_invalid (out_invalid),
        .out_timeout (out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int n_start = 0;

    always @(posedge clk) if (core_start === 1'b1) n_start++;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] r;
        logic        inv;
    } vec_t;

    vec_t sv [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in cycle T+1
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        chk("in_ready_before_send", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        step();
        in_valid = 1'b0;
        in_a     = 32'd0;
        in_b     = 32'd0;
        in_op    = 2'd0;
    endtask

    task automatic accept_resp();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("in_ready_after_hs", in_ready, 1'b1);
        chk("out_valid_after_hs", out_valid, 1'b0);
    endtask

    task automatic run_special(input int idx);
        int s0;
        s0 = n_start;
        send(sv[idx].a, sv[idx].b, sv[idx].op);
        chk($sformatf("sp%0d_valid_t1", idx), out_valid, 1'b0);
        chk($sformatf("sp%0d_ready_t1", idx), in_ready, 1'b0);
        step();
        chk($sformatf("sp%0d_valid_t2", idx), out_valid, 1'b1);
        chk($sformatf("sp%0d_result", idx), out_result, sv[idx].r);
        chk($sformatf("sp%0d_invalid", idx), out_invalid, sv[idx].inv);
        chk($sformatf("sp%0d_timeout", idx), out_timeout, 1'b0);
        chk($sformatf("sp%0d_no_start", idx), 32'(n_start - s0), 32'd0);
        accept_resp();
    endtask

    // Core-path op; done arrives dly cycles after core_start, optional stray done in CLASSIFY/ISSUE
    task automatic run_core(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [31:0] ea, input logic [31:0] eb,
                            input logic eop, input int dly, input logic [31:0] res, input logic stray);
        int s0;
        s0 = n_start;
        send(a, b, op);
        if (stray) begin
            core_done   = 1'b1;
            core_result = 32'hDEADBEEF;
        end
        chk({tag, "_start_t1"}, core_start, 1'b0);
        step();
        chk({tag, "_start_t2"}, core_start, 1'b1);
        chk({tag, "_core_a"}, core_a, ea);
        chk({tag, "_core_b"}, core_b, eb);
        chk({tag, "_core_op"}, core_op, eop);
        for (int k = 1; k <= dly; k++) begin
            step();
            core_done   = 1'b0;
            core_result = 32'd0;
            chk({tag, "_wait_valid"}, out_valid, 1'b0);
            chk({tag, "_start_low"}, core_start, 1'b0);
            chk({tag, "_core_b_stable"}, core_b, eb);
        end
        core_done   = 1'b1;
        core_result = res;
        step();
        core_done   = 1'b0;
        core_result = 32'd0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_invalid"}, out_invalid, 1'b0);
        chk({tag, "_timeout"}, out_timeout, 1'b0);
        chk({tag, "_one_start"}, 32'(n_start - s0), 32'd1);
        accept_resp();
    endtask

    initial begin
        int s0;
        sv[0]  = '{32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000, 1'b1};
        sv[1]  = '{32'h80000000, 32'h3F800000, 2'd2, 32'h80000000, 1'b0};
        sv[2]  = '{32'h80000000, 32'h80000000, 2'd0, 32'h80000000, 1'b0};
        sv[3]  = '{32'h7F800000, 32'h3F800000, 2'd0, 32'h7F800000, 1'b0};
        sv[4]  = '{32'h7F800000, 32'h00000000, 2'd2, 32'h7FC00000, 1'b1};
        sv[5]  = '{32'h00000000, 32'h40000000, 2'd0, 32'h40000000, 1'b0};
        sv[6]  = '{32'h00000000, 32'h40000000, 2'd1, 32'hC0000000, 1'b0};
        sv[7]  = '{32'h00000000, 32'h00000000, 2'd1, 32'h00000000, 1'b0};
        sv[8]  = '{32'hFF800000, 32'h40000000, 2'd2, 32'hFF800000, 1'b0};
        sv[9]  = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 1'b1};
        sv[10] = '{32'h3F800000, 32'h40000000, 2'd3, 32'h7FC00000, 1'b1};
        sv[11] = '{32'h00000001, 32'h00000000, 2'd0, 32'h00000001, 1'b0};
        sv[12] = '{32'hFF800000, 32'hFF800000, 2'd1, 32'h7FC00000, 1'b1};
        sv[13] = '{32'h7F800000, 32'h7F800000, 2'd0, 32'h7F800000, 1'b0};
        sv[14] = '{32'h00000000, 32'hFF800000, 2'd2, 32'h7FC00000, 1'b1};
        sv[15] = '{32'h80000000, 32'h80000000, 2'd2, 32'h00000000, 1'b0};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_a        = 32'd0;
        in_b        = 32'd0;
        in_op       = 2'd0;
        core_done   = 1'b0;
        core_result = 32'd0;
        out_ready   = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // add 1.0 + 2.0 through the core, done two cycles after start
        run_core("add", 32'h3F800000, 32'h40000000, 2'd0, 32'h3F800000, 32'h40000000,
                 1'b0, 2, 32'h40400000, 1'b0);
        // sub 1.0 - 2.0 is issued as add with b negated
        run_core("sub", 32'h3F800000, 32'h40000000, 2'd1, 32'h3F800000, 32'hC0000000,
                 1'b0, 1, 32'hBF800000, 1'b0);
        // mul with stray done before WAIT, which must be ignored
        run_core("mul", 32'h40000000, 32'h40400000, 2'd2, 32'h40000000, 32'h40400000,
                 1'b1, 3, 32'h40C00000, 1'b1);
        // denormal operand is finite and goes to the core
        run_core("denorm", 32'h00000001, 32'h3F800000, 2'd0, 32'h00000001, 32'h3F800000,
                 1'b0, 1, 32'h3F800000, 1'b0);
        // done coincident with the last timeout cycle: done wins
        run_core("done_at_to", 32'h3F800000, 32'h3F800000, 2'd0, 32'h3F800000, 32'h3F800000,
                 1'b0, 8, 32'h41000000, 1'b0);

        for (int i = 0; i < 16; i++) run_special(i);

        // timeout: no done, out_valid 9 cycles after core_start
        s0 = n_start;
        send(32'h3F800000, 32'h3F800000, 2'd0);
        step();
        chk("to_start", core_start, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("to_wait_valid", out_valid, 1'b0);
        end
        step();
        chk("to_valid", out_valid, 1'b1);
        chk("to_result", out_result, 32'h7FC00000);
        chk("to_flag", out_timeout, 1'b1);
        chk("to_invalid", out_invalid, 1'b0);
        chk("to_one_start", 32'(n_start - s0), 32'd1);
        // late done and out_ready low for 5 cycles: response must hold
        core_done   = 1'b1;
        core_result = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            step();
            core_done   = 1'b0;
            core_result = 32'd0;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", out_result, 32'h7FC00000);
            chk("hold_timeout", out_timeout, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        accept_resp();

        // reset during WAIT aborts immediately
        s0 = n_start;
        send(32'h3F800000, 32'h40000000, 2'd2);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_core_a", core_a, 32'd0);
        chk("abort_core_b", core_b, 32'd0);
        chk("abort_core_op", core_op, 1'b0);
        chk("abort_out_result", out_result, 32'd0);
        chk("abort_out_timeout", out_timeout, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("abort_no_valid", out_valid, 1'b0);
        end
        chk("abort_one_start", 32'(n_start - s0), 32'd1);
        run_core("post_rst", 32'h40000000, 32'h40000000, 2'd0, 32'h40000000, 32'h40000000,
                 1'b0, 1, 32'h40800000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_op_sequencer.md
# fp_op_sequencer

Controller that sequences one single-precision IEEE-754 operation at a time through the team's shared multi-cycle FP arithmetic core. Accepts an operand pair and opcode over a valid/ready handshake, classifies both operands (zero / infinity / NaN / finite) and resolves special cases locally without using the core. Otherwise it issues the operation to the core, waits for completion with a timeout, and returns the result over a valid/ready handshake. Sits between the instruction front end and the FP core.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT before abort; legal range 2..255.
- QNAN, 32'h7FC00000: canonical quiet NaN returned for invalid operations.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_a, in_b  in  32  operands, IEEE-754 single.
- in_op  in  2  operation: 0 = add, 1 = sub, 2 = mul, 3 = reserved (treated as invalid).
- core_start  out  1  one-cycle issue pulse.
- core_a, core_b  out  32  registered operands; stable from ISSUE through end of WAIT.
- core_op  out  1  0 = add, 1 = mul (sub is issued as add with core_b sign flipped).
- core_done  in  1  core completion pulse; sampled only in WAIT.
- core_result  in  32  core result; valid with core_done.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer ready.
- out_result  out  32  result.
- out_invalid  out  1  IEEE invalid-operation flag for this result.
- out_timeout  out  1  core did not respond within TIMEOUT cycles.

## Operation
- Classification per operand: zero = exp 0x00 and frac 0; inf = exp 0xFF and frac 0; nan = exp 0xFF and frac ≠ 0. Denormals (exp 0, frac ≠ 0) count as finite and go to the core.
- sub: invert the sign of b before classification. All rules below then apply as for add.
- Add special cases, in priority order:
  - any NaN -> QNAN, invalid=1.
  - +inf with -inf -> QNAN, invalid=1.
  - any inf -> that inf.
  - both zero -> -0 if both signs are 1, else +0.
  - one zero -> the other operand unchanged.
- Mul special cases, in priority order:
  - any NaN -> QNAN, invalid=1.
  - inf × zero -> QNAN, invalid=1.
  - any inf -> inf with sign a^b.
  - any zero -> zero with sign a^b.
- op 3 -> QNAN, invalid=1, no core issue.
- All other combinations are issued to the core.
- FSM states:
  - IDLE -> CLASSIFY on in_valid & in_ready. Operands and op are latched in this cycle.
  - CLASSIFY -> RESP if a special case applies, else -> ISSUE.
  - ISSUE: core_start = 1 for exactly one cycle; clear the wait counter; -> WAIT.
  - WAIT: if core_done, capture core_result, invalid=0 -> RESP. Else if counter == TIMEOUT-1: result = QNAN, out_timeout=1 -> RESP. Else increment the counter.
  - RESP: out_valid=1 -> IDLE on out_ready.
- core_done coincident with the timeout cycle: done wins, no timeout.
- core_done outside WAIT is ignored.
- A core_done arriving after a timeout is ignored.
- out_result / out_invalid / out_timeout are registered and stable while out_valid=1.

## Timing
- Reset (asynchronous, immediate on rst_n low) values:
  - state IDLE, so in_ready=1 (also while rst_n is low).
  - core_start=0, core_a=0, core_b=0, core_op=0.
  - out_valid=0, out_result=0, out_invalid=0, out_timeout=0, wait counter 0.
- Special-case latency: accept at cycle T; out_valid rises at T+2.
- Core-path latency: accept at T; core_start at T+2. If core_done arrives at cycle D, out_valid rises at D+1.
- Timeout: core_start at cycle S with no done; out_valid rises at S+TIMEOUT+1.
- Throughput: one operation in flight. in_ready returns 1 the cycle after the out_valid & out_ready handshake. Back-to-back ops therefore have a minimum 3-cycle spacing.
- rst_n asserted mid-operation: abort immediately. No core_start or out_valid is generated for the aborted op.

## Test plan
- add 0x3F800000 + 0x40000000: core_start once with core_a=0x3F800000, core_b=0x40000000, core_op=0; core_done with 0x40400000 two cycles later -> out_result 0x40400000 one cycle after done, out_invalid=0.
- sub 0x7F800000 − 0x7F800000: no core_start; out_valid at T+2, out_result 0x7FC00000, out_invalid=1.
- mul 0x80000000 × 0x3F800000: no core_start; out_result 0x80000000. Repeat with add 0x80000000 + 0x80000000 -> 0x80000000.
- sub 1.0 − 2.0: core_b = 0xC0000000, core_op=0.
- Core never asserts done with TIMEOUT=8: out_valid 9 cycles after core_start, out_result 0x7FC00000, out_timeout=1. A later stray core_done is ignored.
- Hold out_ready=0 for 5 cycles in RESP: out_valid and out_result stay stable and in_ready stays 0. Separately, drop rst_n during WAIT: all outputs return to reset values at once, and in_ready=1.
